imem_loader: RTL and testbench

//  Program writer for the instruction memory that the fetch path (pc -> imem) reads.

---
 rtl/imem_loader.sv | 136 +++++++++++++
 tb/tb_imem_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: packs a valid/ready byte stream little-endian into 32-bit words
// and writes them to instruction memory at consecutive addresses from BASE_ADDR.
// Keeps the CPU held until a complete program (terminated by byte_last) is loaded.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        overflow_err,
  output logic [15:0] words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [15:0] words_q, words_d;
  logic        last_pending_q, last_pending_d;
  logic        accept;
  logic [15:0] words_inc;

  assign accept    = (state_q == S_RECV) && byte_valid;
  assign words_inc = words_q + 16'd1;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_RECV;
      S_RECV:  if (accept && (k_q == 2'd3 || byte_last)) state_d = S_WRITE;
      S_WRITE: begin
        if (last_pending_q)          state_d = S_DONE;
        else if (words_inc == DEPTH_W) state_d = S_ERR;
        else                         state_d = S_RECV;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    byte_ready   = (state_q == S_RECV);
    wr_en        = (state_q == S_WRITE);
    busy         = (state_q == S_RECV) || (state_q == S_WRITE);
    done         = (state_q == S_DONE);
    overflow_err = (state_q == S_ERR);
    cpu_hold     = (state_q != S_DONE);
  end

  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign words_written = words_q;

  // Datapath next values: byte packing, address/word count advance, load restart.
  always_comb begin
    k_d            = k_q;
    wr_data_d      = wr_data_q;
    wr_addr_d      = wr_addr_q;
    words_d        = words_q;
    last_pending_d = last_pending_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          k_d            = 2'd0;
          wr_data_d      = 32'd0;
          wr_addr_d      = BASE_ADDR;
          words_d        = 16'd0;
          last_pending_d = 1'b0;
        end
      end
      S_RECV: begin
        if (accept) begin
          // Unfilled upper bytes stay zero because the word was cleared beforehand.
          wr_data_d[{k_q, 3'b000} +: 8] = byte_data;
          k_d            = k_q + 2'd1;
          last_pending_d = byte_last;
        end
      end
      S_WRITE: begin
        words_d   = words_inc;
        wr_addr_d = wr_addr_q + 32'd4;
        k_d       = 2'd0;
        wr_data_d = 32'd0;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q            <= 2'd0;
      wr_data_q      <= 32'd0;
      wr_addr_q      <= BASE_ADDR;
      words_q        <= 16'd0;
      last_pending_q <= 1'b0;
    end else begin
      k_q            <= k_d;
      wr_data_q      <= wr_data_d;
      wr_addr_q      <= wr_addr_d;
      words_q        <= words_d;
      last_pending_q <= last_pending_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (DEPTH_WORDS=4 so overflow is reachable).
// Expected writes come from a byte-list model: pack accepted bytes 4 per word.
module tb_imem_loader;

  localparam int DEPTH = 4;
  localparam int CAP   = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_last = 1'b0;
  logic        byte_ready, wr_en, cpu_hold, busy, done, overflow_err;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] words_written;

  imem_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .overflow_err(overflow_err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  stim_q[$];
  logic [63:0] wr_q[$];
  int          acc_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: record writes and accepted bytes between edges.
  always @(negedge clk) begin
    if (reset && byte_valid && byte_ready) acc_cnt++;
    if (reset && wr_en) begin
      wr_q.push_back({wr_addr, wr_data});
      check("ready_low_during_write", {63'd0, byte_ready}, 64'd0);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_case1();
    stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  endtask

  task automatic load_random(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom_range(255)));
  endtask

  // Drive stim_q, optionally pulsing start at byte index start_mid, then check
  // final state against the packing model when finish=1.
  task automatic run_load(input string tag, input bit has_last, input int gap_pct,
                          input int start_mid, input bit skip_start, input bit finish);
    int n, i, cycles, exp_acc, exp_words;
    bit exp_done, exp_err, acc;
    logic [31:0] w;
    n = stim_q.size();
    wr_q.delete();
    acc_cnt = 0;
    if (!skip_start) pulse_start();
    i = 0;
    cycles = 0;
    while (i < n && !(done || overflow_err) && cycles < 500) begin
      byte_valid = ($urandom_range(99) >= gap_pct);
      byte_data  = stim_q[i];
      byte_last  = has_last && (i == n - 1);
      start      = (i == start_mid);
      @(negedge clk);
      acc = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cycles++;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    start      = 1'b0;
    if (!finish) return;
    for (int c = 0; c < 20 && !(done || overflow_err); c++) begin
      @(posedge clk); #1;
    end
    // Bytes offered after completion must be ignored.
    byte_valid = 1'b1; byte_data = 8'hEE; byte_last = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    byte_valid = 1'b0; byte_last = 1'b0;

    exp_acc   = (n < CAP) ? n : CAP;
    exp_done  = has_last && (n <= CAP);
    exp_err   = !exp_done && (n >= CAP);
    exp_words = (exp_acc + 3) / 4;
    check({tag, "_accepted"}, 64'(acc_cnt), 64'(exp_acc));
    check({tag, "_nwrites"}, 64'(wr_q.size()), 64'(exp_words));
    for (int wi = 0; wi < exp_words && wi < wr_q.size(); wi++) begin
      w = 32'd0;
      for (int j = 0; j < 4; j++)
        if (4 * wi + j < exp_acc) w = w | (32'(stim_q[4 * wi + j]) << (8 * j));
      check($sformatf("%s_write%0d", tag, wi), wr_q[wi], {32'(4 * wi), w});
    end
    check({tag, "_done"}, {63'd0, done}, {63'd0, exp_done});
    check({tag, "_overflow"}, {63'd0, overflow_err}, {63'd0, exp_err});
    check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, {63'd0, !exp_done});
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_words_written"}, 64'(words_written), 64'(exp_words));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_en"}, {63'd0, wr_en}, 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check({tag, "_byte_ready"}, {63'd0, byte_ready}, 64'd0);
    check({tag, "_flags"}, {60'd0, cpu_hold, busy, done, overflow_err}, 64'b1000);
    check({tag, "_words_written"}, 64'(words_written), 64'd0);
  endtask

  initial begin
    #12;
    check_reset_values("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Case 1: two full words, valid held high.
    load_case1();
    run_load("case1", 1'b1, 0, -1, 1'b0, 1'b1);

    // Case 2: partial tail word.
    stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hAA};
    run_load("case2", 1'b1, 0, -1, 1'b0, 1'b1);

    // Case 3: random valid gaps on the case 1 stream.
    load_case1();
    run_load("case3", 1'b1, 40, -1, 1'b0, 1'b1);

    // Case 4: overflow, 17 bytes without last.
    load_random(17);
    run_load("case4", 1'b0, 0, -1, 1'b0, 1'b1);

    // Boundary: last byte fills word DEPTH exactly -> DONE.
    load_random(16);
    run_load("exact_fill", 1'b1, 25, -1, 1'b0, 1'b1);

    // Restart out of ERR after an overflow with gaps.
    load_random(20);
    run_load("overflow_gaps", 1'b0, 30, -1, 1'b0, 1'b1);

    // Case 5: reset after two bytes of word 0.
    stim_q = '{8'h13, 8'h00};
    run_load("case5_partial", 1'b0, 0, -1, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_values("midload_reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("case5_no_write", 64'(wr_q.size()), 64'd0);
    load_case1();
    run_load("case5_reload", 1'b1, 0, -1, 1'b0, 1'b1);

    // Case 6: start pulsed mid-load is ignored.
    load_case1();
    run_load("case6_midstart", 1'b1, 20, 5, 1'b0, 1'b1);
    pulse_start();
    check("restart_cpu_hold", {63'd0, cpu_hold}, 64'd1);
    check("restart_words", 64'(words_written), 64'd0);
    check("restart_addr", 64'(wr_addr), 64'd0);
    check("restart_busy", {63'd0, busy}, 64'd1);
    load_random(7);
    run_load("case6_fresh", 1'b1, 20, -1, 1'b1, 1'b1);

    // Random programs of assorted lengths.
    for (int t = 0; t < 6; t++) begin
      load_random(1 + $urandom_range(15));
      run_load($sformatf("rand%0d", t), 1'b1, $urandom_range(50), -1, 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
